// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: the FSM state encoding,
// the terminator byte constants and a small width helper.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_CR,
      S_LF,
      S_DONE
   } state_t;

   localparam logic [7:0] CR   = 8'h0D;
   localparam logic [7:0] LF   = 8'h0A;
   localparam logic [7:0] NULL = 8'h00;

   // Index width that never collapses to zero bits for tiny ranges.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the one-hot index of
// the first set request bit, scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int PW    = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] pick,
   output logic             any
);

   // Scan by rotational distance from ptr so every select index is a
   // loop constant; the closest requesting position wins.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!any && req[j] && (((j + N_REQ - int'(ptr)) % N_REQ) == k)) begin
               pick[j] = 1'b1;
               any     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte-stream
// requesters with packet-granular round-robin arbitration, and sequences each
// byte through the transmit pulse / is_transmitting rise-and-fall handshake.
// Optional: define UART_ARB_CRLF_EN to append CR, LF after every packet.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int N_REQ         = 2,
   parameter int START_TIMEOUT = 1023,
   parameter int CW            = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic [CW-1:0]      pkt_count,
   output logic               transmit,
   output logic [7:0]         tx_byte,
   input  logic               is_transmitting
);

   localparam int PW = clog2_min1(N_REQ);
   localparam int TW = clog2_min1(START_TIMEOUT + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_REQ-1:0]   r_grant;
   logic               r_busy;
   logic [CW-1:0]      r_pkt_count;
   logic [7:0]         r_tx_byte;
   logic               r_last;
   logic [PW-1:0]      r_ptr;
   logic [TW-1:0]      r_cnt;
`ifdef UART_ARB_CRLF_EN
   // 0: data bytes, 1: CR in flight, 2: LF in flight
   logic [1:0]         r_term;
`endif

   logic [N_REQ-1:0]   w_pick;
   logic               w_any;
   logic [PW-1:0]      w_gidx;
   logic [7:0]         w_gdata;
   logic               w_glast;
   logic               w_gvalid;
   logic [PW-1:0]      w_ptr_nxt;
   logic               w_timeout;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .req  (req_valid),
      .ptr  (r_ptr),
      .pick (w_pick),
      .any  (w_any)
   );

   // Mux out the granted requester's index, byte and last flag.
   always_comb begin
      w_gidx  = '0;
      w_gdata = NULL;
      w_glast = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (r_grant[j]) begin
            w_gidx  = PW'(j);
            w_gdata = req_data[j*8 +: 8];
            w_glast = req_last[j];
         end
      end
   end

   assign w_gvalid  = |(req_valid & r_grant);
   assign w_ptr_nxt = (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
   // Re-pulse after START_TIMEOUT cycles in S_WAIT_HI without a rise.
   assign w_timeout = (r_cnt == TW'(START_TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic; a stalled granted requester holds the UART.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_any) w_state_nxt = S_LOAD;
         S_LOAD:    if (w_gvalid) w_state_nxt = S_START;
         S_START:   w_state_nxt = S_WAIT_HI;
         S_WAIT_HI: begin
            if (is_transmitting)  w_state_nxt = S_WAIT_LO;
            else if (w_timeout)   w_state_nxt = S_START;
         end
         S_WAIT_LO: begin
            if (!is_transmitting) begin
               if (!r_last) w_state_nxt = S_LOAD;
               else begin
`ifdef UART_ARB_CRLF_EN
                  case (r_term)
                     2'd0:    w_state_nxt = S_CR;
                     2'd1:    w_state_nxt = S_LF;
                     default: w_state_nxt = S_DONE;
                  endcase
`else
                  w_state_nxt = S_DONE;
`endif
               end
            end
         end
`ifdef UART_ARB_CRLF_EN
         S_CR:      w_state_nxt = S_START;
         S_LF:      w_state_nxt = S_START;
`endif
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers updated according to the current state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grant     <= '0;
         r_busy      <= 1'b0;
         r_pkt_count <= '0;
         r_tx_byte   <= NULL;
         r_last      <= 1'b0;
         r_ptr       <= '0;
         r_cnt       <= '0;
`ifdef UART_ARB_CRLF_EN
         r_term      <= 2'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               if (w_gvalid) begin
                  r_tx_byte <= w_gdata;
                  r_last    <= w_glast;
               end
            end
            S_START:   r_cnt <= '0;
            S_WAIT_HI: if (!is_transmitting) r_cnt <= r_cnt + 1'b1;
`ifdef UART_ARB_CRLF_EN
            S_CR: begin
               r_tx_byte <= CR;
               r_term    <= 2'd1;
            end
            S_LF: begin
               r_tx_byte <= LF;
               r_term    <= 2'd2;
            end
`endif
            S_DONE: begin
               r_pkt_count <= r_pkt_count + 1'b1;
               r_ptr       <= w_ptr_nxt;
               r_grant     <= '0;
               r_busy      <= 1'b0;
               r_last      <= 1'b0;
`ifdef UART_ARB_CRLF_EN
               r_term      <= 2'd0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign grant     = r_grant;
   assign busy      = r_busy;
   assign pkt_count = r_pkt_count;
   assign tx_byte   = r_tx_byte;
   assign transmit  = (r_state == S_START);
   assign req_ready = (r_state == S_LOAD) ? r_grant : '0;

endmodule
